// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog
//
// Serial pattern detector with a pattern register that can be reloaded at run
// time. It watches a 1-bit stream that is qualified by a valid strobe. When the
// last PAT_W valid bits equal the pattern register, it raises a one-cycle pulse.
// Detection can be overlapping or non-overlapping. This block sits between a
// serial bit source and downstream event/interrupt logic.
//
// Optional feature (compile-time macro SEQ_DET_CNT_EN):
//   defined   : det_cnt counts detections, saturates at 2^CNT_W-1, and is
//               cleared by cnt_clr. cnt_clr wins over an increment in the same
//               cycle.
//   undefined : det_cnt is tied to 0, cnt_clr is ignored, and no counter flops
//               exist.
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   PAT_RST  pattern loaded at reset; MSB is the oldest bit
//   CNT_W    width of the detection counter
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-low reset
//   seq_in    serial data bit
//   seq_vld   seq_in is sampled only when this is 1
//   ovl_en    1 = overlapping detection, 0 = non-overlapping
//   pat_load  load pat_in into the pattern register (ignores seq_in that cycle)
//   pat_in    new pattern; MSB is the oldest bit
//   cnt_clr   clear det_cnt
//   det_o     one-cycle detection pulse (registered)
//   det_cnt   saturating detection count (registered)
//   pat_o     current pattern register (registered)
//
// Handshake: seq_in is consumed on every rising edge where seq_vld=1 and
// pat_load=0. There is no back-pressure; the block accepts one bit per cycle.
// Per-edge priority: rst > pat_load > seq_vld.
// -----------------------------------------------------------------------------
module seq_det_prog #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PAT_RST = 5'b10110,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seq_in,
   input  logic             seq_vld,
   input  logic             ovl_en,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             det_o,
   output logic [CNT_W-1:0] det_cnt,
   output logic [PAT_W-1:0] pat_o
);

   // fill must be able to hold the value PAT_W itself
   localparam int              FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PAT_W-1:0]  pat_reg;
   logic [PAT_W-1:0]  hist;     // shift history, newest bit in LSB
   logic [FILL_W-1:0] fill;     // number of valid bits held in hist
   logic              det_q;

   // ---------------------------------------------------------------------------
   // Next-state signals
   // ---------------------------------------------------------------------------
   logic [PAT_W-1:0]  hist_sh;  // hist with seq_in shifted in
   logic [FILL_W-1:0] fill_inc; // fill+1, capped at PAT_W
   logic              match;
   logic [PAT_W-1:0]  pat_nx;
   logic [PAT_W-1:0]  hist_nx;
   logic [FILL_W-1:0] fill_nx;
   logic              det_nx;

   always_comb begin
      hist_sh  = {hist[PAT_W-2:0], seq_in};
      fill_inc = (fill == FULL) ? fill : fill + 1'b1;
      match    = (fill_inc == FULL) && (hist_sh == pat_reg);

      pat_nx  = pat_reg;
      hist_nx = hist;
      fill_nx = fill;
      det_nx  = 1'b0;

      if (pat_load) begin
         // A new pattern invalidates any partial match against the old one
         pat_nx  = pat_in;
         hist_nx = '0;
         fill_nx = '0;
      end else if (seq_vld) begin
         hist_nx = hist_sh;
         det_nx  = match;
         // Non-overlapping mode: after a hit, the next hit needs PAT_W fresh
         // bits. Clearing fill is enough; stale hist bits are ignored until
         // fill reaches PAT_W again.
         if (match && !ovl_en) begin
            fill_nx = '0;
         end else begin
            fill_nx = fill_inc;
         end
      end
      // seq_vld=0: hist/fill hold, so a gap does not break a partial match
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pat_reg <= PAT_RST;
         hist    <= '0;
         fill    <= '0;
         det_q   <= 1'b0;
      end else begin
         pat_reg <= pat_nx;
         hist    <= hist_nx;
         fill    <= fill_nx;
         det_q   <= det_nx;
      end
   end

   assign det_o = det_q;
   assign pat_o = pat_reg;

   // ---------------------------------------------------------------------------
   // Detection counter
   // ---------------------------------------------------------------------------
`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Increments on the same edge that sets det_o, so det_cnt and det_o change
   // together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (det_nx && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign det_cnt = cnt_q;
`else
   logic cnt_clr_unused;

   assign cnt_clr_unused = cnt_clr;
   assign det_cnt        = '0;
`endif

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Parametrised successor to the team's fixed-pattern serial sequence detector.
- Detects a PAT_W-bit pattern on a 1-bit serial stream. The pattern can be reloaded at run time.
- Overlapping or non-overlapping detection is selectable, input is qualified by a valid strobe, and an optional saturating hit counter is available.
- Sits between a serial bit source and downstream event/interrupt logic.

Parameters:
- PAT_W, 5, pattern length in bits; legal range 2..32.
- PAT_RST, 5'b10110, pattern loaded at reset; MSB is the oldest bit.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- seq_in  input  1  serial data bit.
- seq_vld  input  1  seq_in is sampled only when this is 1.
- ovl_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern; MSB is the oldest bit.
- cnt_clr  input  1  clear det_cnt.
- det_o  output  1  one-cycle detection pulse.
- det_cnt  output  CNT_W  number of detections, saturating.
- pat_o  output  PAT_W  current pattern register.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pat_reg=PAT_RST, hist=0, fill=0.
  - det_o=0, det_cnt=0.
  - Reset overrides all other inputs, including in mid-pattern.
- State:
  - hist[PAT_W-1:0] is a shift history; the newest bit is in the LSB.
  - fill (0..PAT_W) counts the valid bits in hist.
- Priority per edge: reset > pat_load > seq_vld.
- pat_load=1:
  - pat_reg<=pat_in, hist<=0, fill<=0, det_o<=0.
  - seq_in is ignored that cycle even if seq_vld=1.
- seq_vld=1, pat_load=0:
  - hist_nx={hist[PAT_W-2:0],seq_in}.
  - fill_nx=min(fill+1,PAT_W).
  - match=(fill_nx==PAT_W)&&(hist_nx==pat_reg).
  - det_o<=match. det_o rises on the edge that samples the final pattern bit and stays high exactly one cycle.
  - If match && ovl_en==0: fill<=0, so the next detection needs PAT_W fresh bits.
  - Otherwise fill<=fill_nx.
  - hist<=hist_nx.
- seq_vld=0: hist and fill hold, det_o<=0. Gaps in seq_vld do not break a partial match.
- ovl_en is sampled on every valid cycle; a change affects only subsequent matches.
- Back-to-back detections in overlap mode give consecutive det_o pulses. Example: all-ones pattern with a continuous 1 stream gives one pulse per valid cycle once fill==PAT_W.
- det_cnt: see the optional feature. cnt_clr has priority over an increment in the same cycle, so the result is 0.
- pat_o = pat_reg, registered.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined:
  - det_cnt<=det_cnt+1 on each det_o assertion.
  - det_cnt saturates at 2^CNT_W-1.
  - cnt_clr=1 forces det_cnt<=0.
- Undefined:
  - det_cnt is tied to 0 and cnt_clr is ignored.
  - No counter flops are synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset, then ovl_en=1, seq_vld=1, stream 1,0,1,1,0,1,1,0 -> det_o high after the 5th and 8th bits only; det_cnt=2 (with SEQ_DET_CNT_EN).
- Same stream with ovl_en=0 -> det_o high after the 5th bit only; det_cnt=1.
- Stream 1,0,1 then seq_vld=0 for 3 cycles, then 1,0 -> det_o pulses once, on the edge sampling the final 0.
- pat_load with pat_in=5'b11111, then 7 valid 1s with ovl_en=1 -> det_o high on bits 5,6,7 (3 consecutive cycles); pat_o=5'b11111.
- Mid-pattern (after 1,0,1,1), drive rst=0 for one cycle, then send 0 -> no det_o; all outputs 0 during reset; pat_o=5'b10110.
- With CNT_W=2, produce 5 detections -> det_cnt saturates at 3. Assert cnt_clr in the same cycle as a detection -> det_cnt=0.
